// File: rtl/opo_package.sv
// Shared constants and sample type for the OPO locking datapath.
// Imported by the low-pass filter top and its averaging stage.
package opo_package;

    localparam int word_width = 16;
    localparam int max_stages = 256;

    typedef logic signed [word_width-1:0] sample_t;

endpackage

// File: rtl/lpf_avg_stage.sv
// One two-tap averaging stage: out = floor((x + x_prev) / 2) when enabled,
// a plain registered copy of x when disabled, so latency is always one clock.
module lpf_avg_stage
    import opo_package::*;
#(
    parameter int word_width = opo_package::word_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [word_width-1:0] in,
    input  logic                  in_valid,
    output logic [word_width-1:0] out,
    output logic                  out_valid
);

    logic [word_width-1:0] x_prev;
    logic [word_width:0]   sum;
    logic [word_width-1:0] avg;
    logic                  unused_sum_lsb;

    // Sign-extended one bit so the sum never overflows; dropping the LSB of a
    // two's complement value is an arithmetic shift, i.e. floor division.
    assign sum            = {in[word_width-1], in} + {x_prev[word_width-1], x_prev};
    assign avg            = sum[word_width:1];
    assign unused_sum_lsb = sum[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            x_prev    <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            out       <= enable ? avg : in;
            x_prev    <= in;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cascade_lowpass_filter.sv
// Chain of num_stages averaging stages giving a binomial low-pass response.
// num_stages = 0 degenerates to a combinational passthrough.
module cascade_lowpass_filter
    import opo_package::*;
#(
    parameter int num_stages = 1,
    parameter int word_width = opo_package::word_width
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [((num_stages > 0) ? num_stages : 1)-1:0]  stage_enable,
    input  logic [word_width-1:0]                           data_in,
    input  logic                                            data_in_valid,
    output logic [word_width-1:0]                           data_out,
    output logic                                            data_out_valid
);

    // data_in_valid qualifies data_in; there is no ready, so every valid cycle
    // is consumed and data_out_valid marks each result exactly once.
    generate
        if (num_stages == 0) begin : g_passthrough
            logic unused_ctrl;

            assign unused_ctrl    = ^{clk, rst, stage_enable};
            assign data_out       = data_in;
            assign data_out_valid = data_in_valid;
        end else begin : g_chain
            logic [word_width-1:0] chain_data  [0:num_stages];
            logic                  chain_valid [0:num_stages];

            assign chain_data[0]  = data_in;
            assign chain_valid[0] = data_in_valid;

            for (genvar k = 0; k < num_stages; k++) begin : g_stage
                lpf_avg_stage #(
                    .word_width (word_width)
                ) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .enable    (stage_enable[k]),
                    .in        (chain_data[k]),
                    .in_valid  (chain_valid[k]),
                    .out       (chain_data[k+1]),
                    .out_valid (chain_valid[k+1])
                );
            end

            assign data_out       = chain_data[num_stages];
            assign data_out_valid = chain_valid[num_stages];
        end
    endgenerate

endmodule

// File: tb/tb_cascade_lowpass_filter.sv
// Directed bench for cascade_lowpass_filter: several chain lengths share one
// stimulus bus; each test group checks the instance it targets.
module tb_cascade_lowpass_filter;

    logic        clk;
    logic        rst;
    logic [15:0] en;
    logic [15:0] din;
    logic        vin;

    logic [15:0] o0, o1, o2, o4, o8, o16;
    logic        v0, v1, v2, v4, v8, v16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] en;
        logic [15:0] din;
        logic        vin;
        logic [15:0] exp;
        logic        exp_v;
    } vec_t;

    vec_t vq[$];

    cascade_lowpass_filter #(.num_stages(0)) u0 (
        .clk(clk), .rst(rst), .stage_enable(en[0:0]), .data_in(din),
        .data_in_valid(vin), .data_out(o0), .data_out_valid(v0));
    cascade_lowpass_filter #(.num_stages(1)) u1 (
        .clk(clk), .rst(rst), .stage_enable(en[0:0]), .data_in(din),
        .data_in_valid(vin), .data_out(o1), .data_out_valid(v1));
    cascade_lowpass_filter #(.num_stages(2)) u2 (
        .clk(clk), .rst(rst), .stage_enable(en[1:0]), .data_in(din),
        .data_in_valid(vin), .data_out(o2), .data_out_valid(v2));
    cascade_lowpass_filter #(.num_stages(4)) u4 (
        .clk(clk), .rst(rst), .stage_enable(en[3:0]), .data_in(din),
        .data_in_valid(vin), .data_out(o4), .data_out_valid(v4));
    cascade_lowpass_filter #(.num_stages(8)) u8 (
        .clk(clk), .rst(rst), .stage_enable(en[7:0]), .data_in(din),
        .data_in_valid(vin), .data_out(o8), .data_out_valid(v8));
    cascade_lowpass_filter #(.num_stages(16)) u16 (
        .clk(clk), .rst(rst), .stage_enable(en[15:0]), .data_in(din),
        .data_in_valid(vin), .data_out(o16), .data_out_valid(v16));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] get_out(input int sel);
        case (sel)
            1:       return o1;
            2:       return o2;
            4:       return o4;
            8:       return o8;
            16:      return o16;
            default: return o0;
        endcase
    endfunction

    function automatic logic get_valid(input int sel);
        case (sel)
            1:       return v1;
            2:       return v2;
            4:       return v4;
            8:       return v8;
            16:      return v16;
            default: return v0;
        endcase
    endfunction

    // scoreboard
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic apply_reset();
        rst = 1'b1;
        din = '0;
        vin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] e, input logic [15:0] d, input logic v,
                        input logic [15:0] x, input logic xv);
        vec_t r;
        r.en    = e;
        r.din   = d;
        r.vin   = v;
        r.exp   = x;
        r.exp_v = xv;
        vq.push_back(r);
    endtask

    // Drives one vector per clock; also checks the zero-stage passthrough
    // combinationally before the edge.
    task automatic run_table(input int sel, input string name);
        for (int i = 0; i < vq.size(); i++) begin
            en  = vq[i].en;
            din = vq[i].din;
            vin = vq[i].vin;
            #1;
            check($sformatf("%s_pass_data[%0d]", name, i), o0, vq[i].din);
            check($sformatf("%s_pass_valid[%0d]", name, i), {15'd0, v0}, {15'd0, vq[i].vin});
            @(posedge clk);
            #1;
            check($sformatf("%s_data[%0d]", name, i), get_out(sel), vq[i].exp);
            check($sformatf("%s_valid[%0d]", name, i), {15'd0, get_valid(sel)}, {15'd0, vq[i].exp_v});
        end
        vq.delete();
    endtask

    logic [15:0] prev;

    initial begin
        rst = 1'b1;
        en  = '0;
        din = 16'h1234;
        vin = 1'b1;
        #3;
        check("reset_o1", o1, 16'h0000);
        check("reset_v1", {15'd0, v1}, 16'd0);
        check("reset_o16", o16, 16'h0000);
        check("reset_v16", {15'd0, v16}, 16'd0);
        check("reset_pass_data", o0, 16'h1234);
        check("reset_pass_valid", {15'd0, v0}, 16'd1);

        // one enabled stage: step, floor rounding, enable toggling, Nyquist extremes
        apply_reset();
        push(16'h1, 16'h0000, 1, 16'h0000, 1);
        push(16'h1, 16'h1000, 1, 16'h0800, 1);
        push(16'h1, 16'h1000, 1, 16'h1000, 1);
        push(16'h1, 16'hFFFD, 1, 16'h07FE, 1);
        push(16'h1, 16'hFFFC, 1, 16'hFFFC, 1);
        push(16'h1, 16'h5555, 0, 16'hFFFC, 0);
        push(16'h1, 16'h0100, 1, 16'h007E, 1);
        push(16'h0, 16'h0300, 1, 16'h0300, 1);
        push(16'h1, 16'h0100, 1, 16'h0200, 1);
        push(16'h1, 16'h7FFF, 1, 16'h407F, 1);
        push(16'h1, 16'h8000, 1, 16'hFFFF, 1);
        push(16'h1, 16'h7FFF, 1, 16'hFFFF, 1);
        push(16'h1, 16'h8000, 1, 16'hFFFF, 1);
        push(16'h1, 16'h8000, 1, 16'h8000, 1);
        push(16'h1, 16'h7FFF, 1, 16'hFFFF, 1);
        run_table(1, "n1");

        // two stages with valid gaps: x_prev must hold across invalid cycles
        apply_reset();
        push(16'hFFFF, 16'h0100, 1, 16'h0000, 0);
        push(16'hFFFF, 16'h7777, 0, 16'h0040, 1);
        push(16'hFFFF, 16'h7777, 0, 16'h0040, 0);
        push(16'hFFFF, 16'h0200, 1, 16'h0040, 0);
        push(16'hFFFF, 16'h7777, 0, 16'h0100, 1);
        push(16'hFFFF, 16'h7777, 0, 16'h0100, 0);
        run_table(2, "n2_gap");

        // four disabled stages: pure four-clock delay of a ramp
        apply_reset();
        for (int t = 1; t <= 13; t++) begin
            if (t - 3 < 1)
                push(16'h0, (t <= 8) ? 16'(t) : 16'h0, t <= 8, 16'h0000, 0);
            else if (t - 3 <= 8)
                push(16'h0, (t <= 8) ? 16'(t) : 16'h0, t <= 8, 16'(t - 3), 1);
            else
                push(16'h0, 16'h0, 0, 16'h0008, 0);
        end
        run_table(4, "n4_bypass");

        // eight enabled stages, DC input: monotone ramp, settled from 9th valid output
        apply_reset();
        en   = 16'hFFFF;
        din  = 16'h03E8;
        vin  = 1'b1;
        prev = '0;
        for (int t = 1; t <= 24; t++) begin
            @(posedge clk);
            #1;
            check($sformatf("dc_valid[%0d]", t), {15'd0, v8}, (t >= 8) ? 16'd1 : 16'd0);
            if (t < 8)
                check($sformatf("dc_idle[%0d]", t), o8, 16'h0000);
            else
                check($sformatf("dc_monotone[%0d]", t), {15'd0, o8 >= prev}, 16'd1);
            if (t == 15)
                check("dc_not_yet_settled", {15'd0, o8 < 16'h03E8}, 16'd1);
            if (t >= 16)
                check($sformatf("dc_settled[%0d]", t), o8, 16'h03E8);
            prev = o8;
        end

        // sixteen stages: async reset mid-stream, then start-up from x_prev=0
        apply_reset();
        en  = 16'hFFFF;
        din = 16'h2000;
        vin = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_before_data", o16, 16'h2000);
        check("midrst_before_valid", {15'd0, v16}, 16'd1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_o16", o16, 16'h0000);
        check("midrst_v16", {15'd0, v16}, 16'd0);
        check("midrst_o1", o1, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        din = 16'h0400;
        for (int t = 1; t <= 16; t++) begin
            @(posedge clk);
            #1;
            if (t == 1)
                check("restart_o1", o1, 16'h0200);
            if (t == 15)
                check("restart_v16_early", {15'd0, v16}, 16'd0);
            if (t == 16) begin
                check("restart_v16", {15'd0, v16}, 16'd1);
                check("restart_o16", o16, 16'h0000);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cascade_lowpass_filter.md
Name: cascade_lowpass_filter

Overview:
Configurable pipelined low-pass filter built from a chain of identical two-tap averaging stages. Each stage can be enabled individually. N enabled stages give a binomial (sinc^2-like) response with roughly N/2 samples of smoothing. The block sits in the OPO locking datapath after the demodulator/sine reference and before the lock error computation. N = 0 gives a passthrough.

Parameters:
num_stages, 1, number of cascaded averaging stages (0 = passthrough; system builds use 0..256, powers of two)
word_width, 16, sample width, signed two's complement

Ports:
clk  in  1  system clock (250 MHz)
rst  in  1  asynchronous, active-high reset
stage_enable  in  max(num_stages,1)  bit k enables stage k; ignored when num_stages=0
data_in  in  word_width  input sample, signed
data_in_valid  in  1  qualifies data_in
data_out  out  word_width  filtered sample, signed
data_out_valid  out  1  qualifies data_out

Behaviour:
- Reset (async assert, clocked release): every stage's output register, previous-sample register and valid flag clear to 0. data_out=0 and data_out_valid=0 while rst is high.
- num_stages=0:
  - data_out=data_in and data_out_valid=data_in_valid, combinational.
  - Zero latency; clk, rst and stage_enable are unused.
- Stage k input:
  - Stage 0 takes data_in / data_in_valid.
  - Stage k>0 takes the output and valid of stage k-1.
- Stage k on a clock where its input valid is high:
  - enabled: out <= floor((x + x_prev) / 2). Sum is formed at word_width+1 bits, then arithmetic shift right by 1. No overflow is possible.
  - disabled: out <= x (registered passthrough, so latency does not depend on the enables).
  - In both cases x_prev <= x and valid_out <= 1.
- Stage k on a clock where its input valid is low: out and x_prev hold; valid_out <= 0.
- Latency: exactly num_stages clocks from data_in to data_out. The valid pattern is reproduced delayed by num_stages.
- No backpressure. A sample is accepted on every valid cycle.
- stage_enable is sampled per stage, per valid sample. A change affects the next sample that reaches that stage; samples already in the pipeline are not reprocessed.
- The first sample after reset is averaged with x_prev=0, giving a start-up transient. The output settles after num_stages valid samples of constant input.
- The DC gain of each stage is exactly 1: a constant input yields the same constant at the output.
- At Nyquist, alternating +A/-A, one enabled stage yields 0 or -1 (floor rounding).
- Reset asserted mid-stream clears the whole pipeline immediately. There is no partial flush.

Decomposition:
- Shared package (opo_package) holds: word_width, the sample type (signed logic [word_width-1:0]), and the maximum stage count constant.
- Natural sub-module: lpf_avg_stage. It has ports clk, rst, enable, in, in_valid, out, out_valid, and a single register stage.
- The top level is a generate loop chaining num_stages instances, with a special case for num_stages=0.

Test Plan:
- DC settling: num_stages=8, all enabled, data_in=0x03E8 valid every cycle from reset → output ramps up, and data_out=0x03E8 from the 9th valid output onward.
- Step and rounding: num_stages=1, enabled; feed 0, then 0x1000, 0x1000 → outputs 0x0000, 0x0800, 0x1000. Feed -3 then -4 → second output is -4 (0xFFFC).
- Disabled stages: num_stages=4, stage_enable=0; feed a ramp 1,2,3… → data_out equals data_in delayed exactly 4 clocks, and valid is delayed 4 clocks.
- Valid gaps: num_stages=2, all enabled; apply valid in a 1-0-0-1 pattern with data 0x0100, 0x0200 → x_prev holds across gaps, out_valid follows the same pattern delayed 2 clocks, and values match the gap-free reference.
- Frequency sweep: drive a 1024-entry sine (amplitude 0x7FFF) at periods 2..1000 clocks into num_stages 0,1,2,4…256, all enabled → amplitude is monotone non-increasing with stage count at each period, and near-unity for long periods.
- Reset mid-operation: assert rst while a pipeline with num_stages=16 holds nonzero data → data_out=0 and data_out_valid=0 immediately, and after release the first outputs reflect x_prev=0.
